// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: constants shared by the baud generator and the UART TX/RX FSMs.
//   - BAUD_TAB    : the eight selectable baud rates, indexed by baud_sel
//   - baud_sel_e  : symbolic names for the baud_sel codes
//   - OVERSAMPLE_DEF : default os_ticks per bit
//   - baud_inc()  : phase-accumulator increment for one table entry
package uart_baud_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned NUM_RATES      = 8;
    localparam int unsigned SEL_W          = 3;

    // Entry 0 sits in the low word, so BAUD_TAB[sel] is the rate for code sel.
    localparam logic [NUM_RATES-1:0][31:0] BAUD_TAB = {
        32'd921600, 32'd460800, 32'd230400, 32'd115200,
        32'd57600,  32'd38400,  32'd19200,  32'd9600
    };

    typedef enum logic [SEL_W-1:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4,
        BAUD_230400 = 3'd5,
        BAUD_460800 = 3'd6,
        BAUD_921600 = 3'd7
    } baud_sel_e;

    // round(baud * oversample * 2^acc_w / clk_hz). The product stays below
    // 2^48 for every table rate at ACC_W = 24, so 64-bit math is ample.
    function automatic longint unsigned baud_inc(
        input longint unsigned clk_hz,
        input int unsigned     oversample,
        input int unsigned     acc_w,
        input int unsigned     idx
    );
        longint unsigned num;
        num = (longint'(BAUD_TAB[idx]) * longint'(oversample)) << acc_w;
        return (num + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control and tick bundle between the baud generator and
// the UART TX/RX FSMs.
//   en, resync, baud_sel : controls, driven by the FSM side (master)
//   os_tick, bit_tick, mid_tick : one-cycle tick pulses from the generator (slave)
interface uart_baud_gen_if import uart_baud_pkg::*; ();

    logic             en;
    logic             resync;
    logic [SEL_W-1:0] baud_sel;
    logic             os_tick;
    logic             bit_tick;
    logic             mid_tick;

    modport master (
        output en, resync, baud_sel,
        input  os_tick, bit_tick, mid_tick
    );

    modport slave (
        input  en, resync, baud_sel,
        output os_tick, bit_tick, mid_tick
    );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional baud-tick generator.
// A phase accumulator adds INC[sel_q] every enabled cycle; its carry is the
// oversampling tick. A small phase counter over the carries marks bit end
// (bit_tick) and bit centre (mid_tick).
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : uart_baud_gen_if.slave (en, resync, baud_sel in; os/bit/mid ticks out)
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned ACC_W      = 24
) (
    input  logic            clk,
    input  logic            rst,
    uart_baud_gen_if.slave  bus
);

    localparam int unsigned     PH_W    = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

    // The phase counter relies on natural binary wrap at OVERSAMPLE.
    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_chk
        $error("uart_baud_gen: OVERSAMPLE must be a power of two >= 4");
    end

    logic [ACC_W-1:0] inc_tab [NUM_RATES];

    for (genvar i = 0; i < NUM_RATES; i++) begin : g_inc
        localparam longint unsigned INC = baud_inc(longint'(CLK_HZ), OVERSAMPLE, ACC_W, i);
        // A zero increment never ticks; one at or above 2^ACC_W cannot be
        // represented and would alias to a wrong rate.
        if (INC == 0 || INC >= (64'd1 << ACC_W)) begin : g_inc_chk
            $error("uart_baud_gen: increment out of range for rate index %0d", i);
        end
        assign inc_tab[i] = INC[ACC_W-1:0];
    end

    logic [ACC_W-1:0] acc, acc_d;
    logic [PH_W-1:0]  ph, ph_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             os_q, os_d;
    logic             bit_q, bit_d;
    logic             mid_q, mid_d;
    logic [ACC_W:0]   sum;
    logic             carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            ph    <= '0;
            sel_q <= '0;
            os_q  <= 1'b0;
            bit_q <= 1'b0;
            mid_q <= 1'b0;
        end else begin
            acc   <= acc_d;
            ph    <= ph_d;
            sel_q <= sel_d;
            os_q  <= os_d;
            bit_q <= bit_d;
            mid_q <= mid_d;
        end
    end

    // Priority: resync > rate change > disabled > count. Both restarts clear
    // the accumulator and phase and swallow any carry from this edge, so the
    // next bit starts a full bit period later on a clean grid.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, inc_tab[sel_q]};
        carry = sum[ACC_W];
        acc_d = acc;
        ph_d  = ph;
        sel_d = sel_q;
        os_d  = 1'b0;
        bit_d = 1'b0;
        mid_d = 1'b0;
        if (bus.resync) begin
            acc_d = '0;
            ph_d  = '0;
        end else if (bus.baud_sel != sel_q) begin
            sel_d = bus.baud_sel;
            acc_d = '0;
            ph_d  = '0;
        end else if (bus.en) begin
            acc_d = sum[ACC_W-1:0];
            if (carry) begin
                ph_d  = ph + PH_W'(1);
                os_d  = 1'b1;
                bit_d = (ph == PH_LAST);
                mid_d = (ph == PH_MID);
            end
        end
    end

    assign bus.os_tick  = os_q;
    assign bus.bit_tick = bit_q;
    assign bus.mid_tick = mid_q;

endmodule
